// File: rtl/matmul_pkg.sv
// ============================================================================
// Module   : matmul_pkg
// Purpose  : Shared FSM encoding and sizing helpers for matmul_lane_engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int unsigned WORD_W = 32;

    // 32-bit X words that make up one row image of LANES elements
    function automatic int unsigned wpr_of(input int unsigned lanes, input int unsigned dw);
        return (lanes * dw) / WORD_W;
    endfunction

    // index width that never collapses to zero bits
    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mac_lane.sv
// ============================================================================
// Module   : mac_lane
// Purpose  : One unsigned multiply-accumulate lane with clear and enable.
//            MATMUL_SAT_EN selects saturating accumulation (else wraps).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_lane
    import matmul_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ACC_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    x,
    output logic [ACC_W-1:0] acc
);

    localparam int PROD_W = 2 * DW;
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [PROD_W-1:0] prod;
    logic [SUM_W-1:0]  sum;
    logic [ACC_W-1:0]  acc_next;

    always_comb begin
        prod = PROD_W'(a) * PROD_W'(x);
        sum  = SUM_W'(acc_q) + SUM_W'(prod);
`ifdef MATMUL_SAT_EN
        acc_next = (|sum[SUM_W-1:ACC_W]) ? '1 : sum[ACC_W-1:0];
`else
        acc_next = sum[ACC_W-1:0];
`endif
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

`default_nettype wire

// File: rtl/matmul_lane_engine.sv
// ============================================================================
// Module   : matmul_lane_engine
// Purpose  : Y = A*X over LANES parallel MAC lanes with loadable A/X stores,
//            result SRAM and start/busy handshake. MATMUL_SAT_EN: saturate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_lane_engine
    import matmul_pkg::*;
#(
    parameter int LANES          = 4,
    parameter int DW             = 8,
    parameter int ACC_W          = 18,
    parameter int K_MAX          = 16,
    parameter int ROWS_MAX       = 8,
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                load_en,
    input  logic                                valid_input,
    input  logic [31:0]                         PWDATA,
    input  logic                                coef_we,
    input  logic [$clog2(ROWS_MAX*K_MAX)-1:0]   coef_addr,
    input  logic [DW-1:0]                       coef_wdata,
    input  logic [$clog2(K_MAX)-1:0]            k_len,
    input  logic [$clog2(ROWS_MAX)-1:0]         row_cnt,
    input  logic                                start,
    input  logic                                read_n,
    input  logic [APB_ADDR_WIDTH-1:0]           r_addr,
    output logic                                busy,
    output logic                                load_done,
    output logic                                cal_finish,
    output logic                                ry,
    output logic [31:0]                         data_out
);

    localparam int WPR = wpr_of(LANES, DW);
    localparam int KW  = idx_w(K_MAX);
    localparam int RW  = idx_w(ROWS_MAX);
    localparam int LW  = idx_w(LANES);
    localparam int XD  = K_MAX * WPR;
    localparam int XAW = idx_w(XD);
    localparam int PW  = $clog2(XD + 1);
    localparam int AD  = ROWS_MAX * K_MAX;
    localparam int RD  = ROWS_MAX * LANES;
    localparam int RAW = idx_w(RD);

    logic [31:0]   x_mem   [XD];
    logic [DW-1:0] a_mem   [AD];
    logic [31:0]   res_mem [RD];

    state_e        state_q, state_d;
    logic [RW-1:0] row_q, row_d, rcnt_q, rcnt_d;
    logic [KW-1:0] k_q, k_d, klen_q, klen_d;
    logic [LW-1:0] lane_q, lane_d;
    logic [PW-1:0] load_ptr_q, load_ptr_d;
    logic          load_done_q, load_done_d;
    logic          busy_q, busy_d;
    logic          cal_finish_q, cal_finish_d;
    logic          ry_q, ry_d;
    logic [31:0]   data_out_q, data_out_d;

    logic            acc_clr, mac_en, x_we, a_we, res_we, rd_hit;
    logic [KW:0]     klen_eff;
    logic [PW-1:0]   load_target;
    logic [RAW-1:0]  res_waddr;
    logic [31:0]     res_wdata;
    logic [DW-1:0]   a_cur;
    logic [WPR*32-1:0] x_row;
    logic [ACC_W-1:0]  acc_all [LANES];

    assign klen_eff    = (k_len == '0) ? (KW+1)'(K_MAX) : {1'b0, k_len};
    assign load_target = PW'(int'(klen_eff) * WPR);
    assign x_we   = load_en && valid_input && !busy_q && !load_done_q && (load_ptr_q < PW'(XD));
    assign a_we   = coef_we && !busy_q;
    assign mac_en = (state_q == ST_CALC);
    assign res_we = (state_q == ST_WB);
    assign res_waddr = RAW'(int'(row_q) * LANES + int'(lane_q));
    assign res_wdata = 32'(acc_all[lane_q]);
    assign a_cur     = a_mem[{row_q, k_q}];
    assign rd_hit    = (int'(r_addr) < RD);

    // row image of X for the current k; lane l sits at bits [l*DW +: DW]
    always_comb begin
        x_row = '0;
        for (int w = 0; w < WPR; w++) begin
            x_row[w*32 +: 32] = x_mem[XAW'(int'(k_q) * WPR + w)];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mac_lane #(
            .DW    (DW),
            .ACC_W (ACC_W)
        ) u_mac (
            .clk   (clk),
            .rst   (rst),
            .clear (acc_clr),
            .en    (mac_en),
            .a     (a_cur),
            .x     (x_row[l*DW +: DW]),
            .acc   (acc_all[l])
        );
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        k_d        = k_q;
        lane_d     = lane_q;
        klen_d     = klen_q;
        rcnt_d     = rcnt_q;
        acc_clr    = 1'b0;
        load_ptr_d = load_ptr_q;
        load_done_d = load_done_q;

        case (state_q)
            ST_IDLE: begin
                if (start && load_done_q) begin
                    state_d = ST_CALC;
                    row_d   = '0;
                    k_d     = '0;
                    lane_d  = '0;
                    klen_d  = k_len;
                    rcnt_d  = row_cnt;
                    acc_clr = 1'b1;
                end
            end
            ST_CALC: begin
                // k_len/row_cnt of 0 mean the maximum: the -1 wraps to all ones
                if (k_q == klen_q - KW'(1)) begin
                    state_d = ST_WB;
                    k_d     = '0;
                    lane_d  = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_WB: begin
                if (lane_q == LW'(LANES - 1)) begin
                    lane_d = '0;
                    if (row_q == rcnt_q - RW'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                        row_d   = row_q + RW'(1);
                        acc_clr = 1'b1;
                    end
                end else begin
                    lane_d = lane_q + LW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (x_we) begin
            load_ptr_d = load_ptr_q + PW'(1);
        end
        if (!busy_q && !load_done_q && (load_ptr_d >= load_target)) begin
            load_done_d = 1'b1;
        end
        if (state_q == ST_DONE) begin
            load_ptr_d  = '0;
            load_done_d = 1'b0;
        end

        busy_d       = (state_d == ST_CALC) || (state_d == ST_WB);
        cal_finish_d = (state_d == ST_DONE);
        ry_d         = !read_n;
        data_out_d   = data_out_q;
        if (!read_n) begin
            data_out_d = rd_hit ? res_mem[r_addr[RAW-1:0]] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            k_q          <= '0;
            lane_q       <= '0;
            klen_q       <= '0;
            rcnt_q       <= '0;
            load_ptr_q   <= '0;
            load_done_q  <= 1'b0;
            busy_q       <= 1'b0;
            cal_finish_q <= 1'b0;
            ry_q         <= 1'b0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            k_q          <= k_d;
            lane_q       <= lane_d;
            klen_q       <= klen_d;
            rcnt_q       <= rcnt_d;
            load_ptr_q   <= load_ptr_d;
            load_done_q  <= load_done_d;
            busy_q       <= busy_d;
            cal_finish_q <= cal_finish_d;
            ry_q         <= ry_d;
            data_out_q   <= data_out_d;
        end
    end

    // storage arrays survive reset so finished rows stay readable
    always_ff @(posedge clk) begin
        if (x_we) begin
            x_mem[load_ptr_q[XAW-1:0]] <= PWDATA;
        end
        if (a_we) begin
            a_mem[coef_addr] <= coef_wdata;
        end
        if (res_we) begin
            res_mem[res_waddr] <= res_wdata;
        end
    end

    assign busy       = busy_q;
    assign load_done  = load_done_q;
    assign cal_finish = cal_finish_q;
    assign ry         = ry_q;
    assign data_out   = data_out_q;

endmodule

`default_nettype wire

// File: doc/matmul_lane_engine.md
# matmul_lane_engine

Parametrised matrix-multiply engine computing Y = A·X for up to ROWS_MAX output rows across LANES parallel MAC lanes. It is the next generation of the matrix logic top. It replaces the fixed 4-lane ROM-coefficient datapath with a loadable coefficient store, a runtime inner dimension and row count, and a start/busy handshake. X data arrives as 32-bit PWDATA words from the APB side, and results land in an internal result SRAM that the APB side reads back.

## Interface
- LANES, 4, parallel MAC lanes (output columns)
- DW, 8, unsigned element width of A and X
- ACC_W, 18, accumulator width (ACC_W ≤ 32)
- K_MAX, 16, maximum inner dimension (power of 2)
- ROWS_MAX, 8, maximum rows of A (power of 2)
- APB_ADDR_WIDTH, 12, read address width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- load_en  in  1  X load enable
- valid_input  in  1  PWDATA qualifier
- PWDATA  in  32  X word; lane l element in bits [l*DW+DW-1 -: DW] of the row image
- coef_we  in  1  coefficient write strobe
- coef_addr  in  log2(ROWS_MAX*K_MAX)  A index = row*K_MAX + k
- coef_wdata  in  DW  coefficient value
- k_len  in  log2(K_MAX)  inner dimension; 0 means K_MAX
- row_cnt  in  log2(ROWS_MAX)  rows to compute; 0 means ROWS_MAX
- start  in  1  start pulse
- read_n  in  1  active-low result read request
- r_addr  in  APB_ADDR_WIDTH  result index (row*LANES + lane)
- busy  out  1  engine in CALC or WB
- load_done  out  1  X buffer fully loaded
- cal_finish  out  1  one-cycle pulse, whole job complete
- ry  out  1  read data valid
- data_out  out  32  read data

## Operation
- WPR = LANES*DW/32 words per X row. LANES*DW must be a multiple of 32.
- **X load:**
  - While not busy and load_done=0, each cycle with load_en&&valid_input writes PWDATA to X word load_ptr, then increments load_ptr.
  - load_done rises when load_ptr reaches k_len*WPR.
  - Writes are ignored while load_done=1 or busy=1.
- **Coefficient writes:** coef_we writes coef_wdata to the A store. Ignored while busy.
- **FSM IDLE → CALC → WB → (CALC | DONE) → IDLE:**
  - IDLE: start && load_done moves to CALC; row=0, k=0, accumulators cleared. Start is ignored otherwise.
  - CALC: each cycle every lane does acc[l] += A[row][k] * X[k][l]. Moves to WB after k = k_len-1.
  - WB: one result per cycle, lane 0 first. Writes zero-extended acc[l] to result address row*LANES+l. After lane LANES-1: if row = row_cnt-1, go to DONE; else row++, accumulators cleared, go to CALC.
  - DONE: single cycle. cal_finish=1, load_ptr←0, load_done←0, then IDLE.
- **Arithmetic:** unsigned, with a product width of 2*DW. Accumulator behaviour per the Configuration section.
- **Reads:** accepted in any state. On a write and read of the same address in one cycle, the read returns the old data.
- **Reset:** asynchronous and clears everything except the A, X and result memories. The FSM returns to IDLE and all counters go to 0. All outputs (busy, load_done, cal_finish, ry, data_out) reset to 0. A reset mid-job abandons the job; rows already written keep their values.

## Timing
- X write takes effect on the accepting edge. load_done is high on the cycle after the final word.
- start is sampled at the edge and busy is high the next cycle.
- Per row: k_len CALC cycles plus LANES WB cycles. Total from start edge to the cal_finish cycle = row_cnt*(k_len+LANES)+1 cycles.
- busy falls in the cal_finish cycle.
- Result reads: read_n low at edge N gives data_out and ry valid in cycle N+1. ry is a one-cycle pulse per request, and data_out holds until the next read.
- A result written in WB is readable from the following cycle.

## Configuration
- MATMUL_SAT_EN defined: each accumulate step saturates at 2^ACC_W-1.
- MATMUL_SAT_EN undefined: the accumulator wraps modulo 2^ACC_W.

## Structure
- Package matmul_pkg holds:
  - FSM state encoding (IDLE, CALC, WB, DONE)
  - WPR
  - address-width helper constants
- Sub-module mac_lane is one lane's multiply-accumulate. It has clear and enable inputs, and the saturation logic under MATMUL_SAT_EN. The top instantiates it LANES times.

## Test plan
- **Basic job:** LANES=4, k_len=2, row_cnt=1. A[0]=[1,2]. X row0 PWDATA=0x04030201, row1 0x08070605. Start. Expected:
  - results [11,14,17,20] at addresses 0..3
  - cal_finish exactly 2+4+1=7 cycles after start
- **Multi-row with wrap of the row loop:** row_cnt=0 (8 rows), A[r][k]=r+1, X all 1, k_len=4. Expected: address r*4+l reads 4*(r+1); busy high 64 cycles.
- **Saturation:** A=255, X=255, k_len=0 (16). Expected: 262143 with MATMUL_SAT_EN, 253968 without.
- **Handshake guards:** start with load_done=0 is ignored (busy stays 0). Extra X writes and coef writes while busy are ignored, so results are unchanged.
- **Reset mid-CALC:** rst low during row 3. Expected:
  - all outputs 0 immediately
  - rows 0–2 still readable with correct values
  - a fresh load plus start completes normally
- **Read/write collision:** read address 0 in the cycle it is written. Expected: returns the prior value; a read the next cycle returns the new value; ry pulses once per read.
